// File: rtl/arm_controller.sv
`default_nettype none
// ============================================================================
// Module   : arm_controller
// Purpose  : Control unit for the single-cycle ARM datapath. Decodes
//            Instr[31:12], holds the NZCV flag register, evaluates condition
//            codes and sequences LDR/STR through a ready/request handshake
//            with data memory, stalling the PC while an access is pending.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1   clock, rising edge
//   reset        in   1   synchronous reset, active low
//   Instr        in  20   instruction bits [31:12]
//                         ([19:16] Cond, [15:14] Op, [13:8] Funct, [3:0] Rd)
//   ALUFlags     in   4   {N,Z,C,V} from the ALU
//   MemReady     in   1   data memory completes the current access
//   RegSrc       out  2   [0] R15 as RA1, [1] Rd as RA2
//   RegWrite     out  1   register file write enable
//   ImmSrc       out  2   00 imm8, 01 imm12, 10 imm24
//   ALUSrc       out  1   ExtImm as SrcB
//   ALUControl   out  4   ARM data-processing cmd encoding
//   MemtoReg     out  1   ReadData to Result
//   PCSrc        out  1   Result loads PC
//   MemWrite     out  1   data memory write request
//   MemRead      out  1   data memory read request
//   storedCarry  out  1   registered C flag
//   Stall        out  1   hold PC and Instr this cycle
// ----------------------------------------------------------------------------
// Configuration macro
//   ARMCTRL_MEMWAIT_EN  defined  : EXEC/MEMWAIT handshake FSM
//                       undefined: memory ops complete in one cycle,
//                                  MemReady ignored, Stall tied low
// ============================================================================
module arm_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        MemReady,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic [1:0]  ImmSrc,
    output logic        ALUSrc,
    output logic [3:0]  ALUControl,
    output logic        MemtoReg,
    output logic        PCSrc,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        storedCarry,
    output logic        Stall
);

    // Instruction fields (Instr is bits [31:12] of the full word)
    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [3:0] w_cmd;
    logic       w_sbit;
    logic       w_ubit;
    logic [3:0] w_rd;
    logic [3:0] w_unused_rn;

    assign w_cond      = Instr[19:16];
    assign w_op        = Instr[15:14];
    assign w_cmd       = Instr[12:9];
    assign w_sbit      = Instr[8];   // S for DP, L for memory
    assign w_ubit      = Instr[11];
    assign w_rd        = Instr[3:0];
    assign w_unused_rn = Instr[7:4];

    logic w_is_dp, w_is_mem, w_is_branch;
    assign w_is_dp     = (w_op == 2'b00);
    assign w_is_mem    = (w_op == 2'b01);
    assign w_is_branch = (w_op == 2'b10);

    // ------------------------------------------------------------------
    // Flag register {N,Z,C,V}
    // ------------------------------------------------------------------
    logic [3:0] flags_q, flags_d;
    logic       w_n, w_z, w_c, w_v;
    assign {w_n, w_z, w_c, w_v} = flags_q;
    assign storedCarry = flags_q[1];

    // Condition check against the registered flags
    logic w_cond_pass;
    always_comb begin
        w_cond_pass = 1'b0;
        case (w_cond)
            4'b0000: w_cond_pass = w_z;
            4'b0001: w_cond_pass = ~w_z;
            4'b0010: w_cond_pass = w_c;
            4'b0011: w_cond_pass = ~w_c;
            4'b0100: w_cond_pass = w_n;
            4'b0101: w_cond_pass = ~w_n;
            4'b0110: w_cond_pass = w_v;
            4'b0111: w_cond_pass = ~w_v;
            4'b1000: w_cond_pass = w_c & ~w_z;
            4'b1001: w_cond_pass = ~w_c | w_z;
            4'b1010: w_cond_pass = (w_n == w_v);
            4'b1011: w_cond_pass = (w_n != w_v);
            4'b1100: w_cond_pass = ~w_z & (w_n == w_v);
            4'b1101: w_cond_pass = w_z | (w_n != w_v);
            default: w_cond_pass = 1'b1;   // AL, and 1111 treated as AL
        endcase
    end

    // Arithmetic cmds 0010-0111, 1010, 1011 own C and V; the rest keep them
    logic w_arith;
    assign w_arith = (w_cmd[3:1] == 3'b001) || (w_cmd[3:2] == 2'b01) ||
                     (w_cmd[3:1] == 3'b101);

    logic w_flag_we;
    assign w_flag_we = reset & w_is_dp & w_sbit & w_cond_pass;

    always_comb begin
        flags_d = flags_q;
        if (w_flag_we) begin
            flags_d[3:2] = ALUFlags[3:2];
            if (w_arith) begin
                flags_d[1:0] = ALUFlags[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    // ------------------------------------------------------------------
    // Static decode
    // ------------------------------------------------------------------
    logic w_dec_regwrite;
    always_comb begin
        RegSrc         = 2'b00;
        ImmSrc         = 2'b00;
        ALUSrc         = 1'b0;
        ALUControl     = 4'b0100;
        MemtoReg       = 1'b0;
        w_dec_regwrite = 1'b0;
        case (w_op)
            2'b00: begin
                ALUControl     = w_cmd;
                ALUSrc         = Instr[13];
                w_dec_regwrite = (w_cmd[3:2] != 2'b10);  // TST/TEQ/CMP/CMN
            end
            2'b01: begin
                ImmSrc         = 2'b01;
                ALUSrc         = 1'b1;
                ALUControl     = w_ubit ? 4'b0100 : 4'b0010;
                MemtoReg       = w_sbit;
                w_dec_regwrite = w_sbit;
                RegSrc[1]      = ~w_sbit;
            end
            2'b10: begin
                ImmSrc     = 2'b10;
                ALUSrc     = 1'b1;
                RegSrc[0]  = 1'b1;
                ALUControl = 4'b0100;
            end
            default: begin
                ALUControl = 4'b0000;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Memory handshake
    // ------------------------------------------------------------------
    logic w_in_wait;
    logic w_ready;

`ifdef ARMCTRL_MEMWAIT_EN
    typedef enum logic [0:0] {
        EXEC    = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= EXEC;
        end else begin
            state_q <= state_d;
        end
    end

    assign w_in_wait = (state_q == MEMWAIT);
    assign w_ready   = MemReady;
`else
    logic w_unused_ready;
    assign w_unused_ready = MemReady;
    assign w_in_wait      = 1'b0;
    assign w_ready        = 1'b1;
`endif

    // In MEMWAIT the condition already passed at issue; the held
    // instruction keeps its request regardless of the flags.
    logic w_exec_ok, w_mem_req, w_done;
    assign w_exec_ok = w_in_wait | w_cond_pass;
    assign w_mem_req = w_is_mem & w_exec_ok;
    assign w_done    = ~w_mem_req | w_ready;

    always_comb begin
        RegWrite = reset & w_exec_ok & w_done & w_dec_regwrite;
        PCSrc    = reset & w_exec_ok & w_done &
                   (w_is_branch | (w_dec_regwrite & (w_rd == 4'hF)));
        MemRead  = reset & w_mem_req & w_sbit;
        MemWrite = reset & w_mem_req & ~w_sbit;
        Stall    = reset & w_mem_req & ~w_done;
`ifdef ARMCTRL_MEMWAIT_EN
        state_d  = (reset & w_mem_req & ~w_ready) ? MEMWAIT : EXEC;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_arm_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_arm_controller
// Purpose  : Directed self-checking bench for arm_controller. Each step
//            drives inputs on the falling edge, pushes the expected output
//            vector to a scoreboard and compares it 1 ns later.
// Revision : 1.0  initial release
// ============================================================================
module tb_arm_controller;

    logic        clk;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic [1:0]  RegSrc;
    logic        RegWrite;
    logic [1:0]  ImmSrc;
    logic        ALUSrc;
    logic [3:0]  ALUControl;
    logic        MemtoReg;
    logic        PCSrc;
    logic        MemWrite;
    logic        MemRead;
    logic        storedCarry;
    logic        Stall;

    arm_controller dut (
        .clk         (clk),
        .reset       (reset),
        .Instr       (Instr),
        .ALUFlags    (ALUFlags),
        .MemReady    (MemReady),
        .RegSrc      (RegSrc),
        .RegWrite    (RegWrite),
        .ImmSrc      (ImmSrc),
        .ALUSrc      (ALUSrc),
        .ALUControl  (ALUControl),
        .MemtoReg    (MemtoReg),
        .PCSrc       (PCSrc),
        .MemWrite    (MemWrite),
        .MemRead     (MemRead),
        .storedCarry (storedCarry),
        .Stall       (Stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [16:0] exp;
    } sb_t;

    sb_t sb[$];
    int  tests_run = 0;
    int  tests_failed = 0;

    // Output vector order:
    // {RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, PCSrc,
    //  MemWrite, MemRead, storedCarry, Stall}
    function automatic logic [16:0] ev(
        input logic [1:0] rs, input logic rw, input logic [1:0] is,
        input logic as, input logic [3:0] ac, input logic m2r,
        input logic pc, input logic mw, input logic mr,
        input logic sc, input logic st);
        return {rs, rw, is, as, ac, m2r, pc, mw, mr, sc, st};
    endfunction

    task automatic check_out();
        sb_t         e;
        logic [16:0] obs;
        obs = {RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg,
               PCSrc, MemWrite, MemRead, storedCarry, Stall};
        tests_run++;
        if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL scoreboard_empty: observed %b required an entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                tests_failed++;
                $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step(input string tag, input logic rst_n,
                        input logic [19:0] ins, input logic [3:0] af,
                        input logic rdy, input logic [16:0] exp);
        sb_t e;
        @(negedge clk);
        reset    = rst_n;
        Instr    = ins;
        ALUFlags = af;
        MemReady = rdy;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
        #1;
        check_out();
    endtask

    localparam logic [19:0] ADDS   = 20'hE0921;  // ADDS R1,R2,R3
    localparam logic [19:0] SUBS   = 20'hE0500;  // SUBS R0,R0,R0
    localparam logic [19:0] SUBSGE = 20'hA0500;
    localparam logic [19:0] BEQ    = 20'h0A000;
    localparam logic [19:0] BNE    = 20'h1A000;
    localparam logic [19:0] BMI    = 20'h4A000;
    localparam logic [19:0] CMP    = 20'hE1520;  // CMP R2,R3
    localparam logic [19:0] ADC    = 20'hE0A21;  // ADC R1,R2,R3
    localparam logic [19:0] ANDS   = 20'hE0121;  // ANDS R1,R2,R3
    localparam logic [19:0] ADDPC  = 20'hE082F;  // ADD R15,R2,R3
    localparam logic [19:0] ADDGEP = 20'hA082F;  // ADDGE R15,R2,R3
    localparam logic [19:0] ADD    = 20'hE0821;  // ADD R1,R2,R3
    localparam logic [19:0] STR    = 20'hE5821;  // STR R1,[R2,#4]
    localparam logic [19:0] STRNE  = 20'h15821;
    localparam logic [19:0] LDR    = 20'hE5921;  // LDR R1,[R2,#4]
    localparam logic [19:0] LDRM   = 20'hE5121;  // LDR R1,[R2,#-4]

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        Instr    = ADDS;
        ALUFlags = 4'b1111;
        MemReady = 1'b0;
        @(posedge clk);

        // Reset holds enables low and flags at zero
        step("rst_a", 1'b0, ADDS, 4'hF, 1'b0, ev(2'b00,0,2'b00,0,4'b0100,0,0,0,0,0,0));
        step("rst_b", 1'b0, ADDS, 4'hF, 1'b0, ev(2'b00,0,2'b00,0,4'b0100,0,0,0,0,0,0));
        // ADDS writes flags 1111
        step("adds",  1'b1, ADDS, 4'hF, 1'b0, ev(2'b00,1,2'b00,0,4'b0100,0,0,0,0,0,0));
        // SUBS: flags -> 0110
        step("subs",  1'b1, SUBS, 4'h6, 1'b0, ev(2'b00,1,2'b00,0,4'b0010,0,0,0,0,1,0));
        step("beq",   1'b1, BEQ,  4'h0, 1'b0, ev(2'b01,0,2'b10,1,4'b0100,0,1,0,0,1,0));
        step("bne",   1'b1, BNE,  4'h0, 1'b0, ev(2'b01,0,2'b10,1,4'b0100,0,0,0,0,1,0));
        // CMP: no register write, flags -> 0010
        step("cmp",   1'b1, CMP,  4'h2, 1'b0, ev(2'b00,0,2'b00,0,4'b1010,0,0,0,0,1,0));
        // ADC without S: flags unchanged
        step("adc",   1'b1, ADC,  4'hD, 1'b0, ev(2'b00,1,2'b00,0,4'b0101,0,0,0,0,1,0));
        // ANDS: logical writes NZ only -> 1010
        step("ands",  1'b1, ANDS, 4'h9, 1'b0, ev(2'b00,1,2'b00,0,4'b0000,0,0,0,0,1,0));
        // BMI taken; MemReady high outside a request is ignored
        step("bmi",   1'b1, BMI,  4'h0, 1'b1, ev(2'b01,0,2'b10,1,4'b0100,0,1,0,0,1,0));
        step("add_pc",   1'b1, ADDPC,  4'h0, 1'b0, ev(2'b00,1,2'b00,0,4'b0100,0,1,0,0,1,0));
        // GE fails with N=1,V=0
        step("addge_pc", 1'b1, ADDGEP, 4'h0, 1'b0, ev(2'b00,0,2'b00,0,4'b0100,0,0,0,0,1,0));
        // Failed condition must not write flags (still 1010 afterwards)
        step("subsge",   1'b1, SUBSGE, 4'h0, 1'b0, ev(2'b00,0,2'b00,0,4'b0010,0,0,0,0,1,0));
        // SUBS: flags -> 0100 (Z=1)
        step("subs_z",   1'b1, SUBS,   4'h4, 1'b0, ev(2'b00,1,2'b00,0,4'b0010,0,0,0,0,1,0));
        step("strne",    1'b1, STRNE,  4'h0, 1'b0, ev(2'b10,0,2'b01,1,4'b0100,0,0,0,0,0,0));
        step("str",      1'b1, STR,    4'h0, 1'b1, ev(2'b10,0,2'b01,1,4'b0100,0,0,1,0,0,0));
        step("add_post_str", 1'b1, ADD, 4'h0, 1'b0, ev(2'b00,1,2'b00,0,4'b0100,0,0,0,0,0,0));
        step("ldr_minus", 1'b1, LDRM, 4'h0, 1'b1, ev(2'b00,1,2'b01,1,4'b0010,1,0,0,1,0,0));

`ifdef ARMCTRL_MEMWAIT_EN
        for (int i = 0; i < 3; i++) begin
            step("ldr_wait", 1'b1, LDR, 4'h0, 1'b0, ev(2'b00,0,2'b01,1,4'b0100,1,0,0,1,0,1));
        end
        step("ldr_done", 1'b1, LDR, 4'h0, 1'b1, ev(2'b00,1,2'b01,1,4'b0100,1,0,0,1,0,0));
        step("add_post_ldr", 1'b1, ADD, 4'h0, 1'b0, ev(2'b00,1,2'b00,0,4'b0100,0,0,0,0,0,0));
        step("ldr2_wait", 1'b1, LDR, 4'h0, 1'b0, ev(2'b00,0,2'b01,1,4'b0100,1,0,0,1,0,1));
        step("ldr2_rst",  1'b0, LDR, 4'h0, 1'b0, ev(2'b00,0,2'b01,1,4'b0100,1,0,0,0,0,0));
        step("add_post_rst", 1'b1, ADD, 4'h0, 1'b0, ev(2'b00,1,2'b00,0,4'b0100,0,0,0,0,0,0));
`else
        step("ldr_1cyc", 1'b1, LDR, 4'h0, 1'b0, ev(2'b00,1,2'b01,1,4'b0100,1,0,0,1,0,0));
        step("ldr_rst",  1'b0, LDR, 4'h0, 1'b0, ev(2'b00,0,2'b01,1,4'b0100,1,0,0,0,0,0));
        step("add_post_rst", 1'b1, ADD, 4'h0, 1'b0, ev(2'b00,1,2'b00,0,4'b0100,0,0,0,0,0,0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
